muldiv_ctrl: RTL and testbench

//  EX-stage control for MIPS MULT/MULTU/DIV/DIVU; upstream master of div_wrapper.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_mul33.sv | 31 +++
 rtl/muldiv_ctrl.sv | 152 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared opcode codes and FSM encoding for the EX-stage multiply/divide controller.
// Decode and EX import this so the MD_* codes have a single definition.
package muldiv_pkg;

   localparam logic [2:0] MD_NONE  = 3'd0;
   localparam logic [2:0] MD_MULT  = 3'd1;
   localparam logic [2:0] MD_MULTU = 3'd2;
   localparam logic [2:0] MD_DIV   = 3'd3;
   localparam logic [2:0] MD_DIVU  = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DIV_RUN = 2'd1,
      ST_MUL_RUN = 2'd2,
      ST_HOLD    = 2'd3
   } md_state_e;

   function automatic logic md_is_mul(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic md_is_div(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_mul33.sv
// Registered 33x33 signed multiply, one cycle latency; only the low 64 product bits are kept.
// Operands arrive already sign- or zero-extended to 33 bits, so MULT and MULTU share one multiplier.
module muldiv_mul33
   import muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [32:0] a,
   input  logic [32:0] b,
   output logic [63:0] product
);

   logic signed [63:0] a_ext;
   logic signed [63:0] b_ext;
   logic signed [63:0] prod_low;

   // Widening to 64 bits before multiplying yields exactly the low 64 bits of the 66-bit product.
   assign a_ext    = $signed({{31{a[32]}}, a});
   assign b_ext    = $signed({{31{b[32]}}, b});
   assign prod_low = a_ext * b_ext;

   always_ff @(posedge clock) begin
      if (!reset) begin
         product <= '0;
      end else if (load) begin
         product <= prod_low;
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage control for MULT/MULTU/DIV/DIVU: drives an external divider, owns the multiplier,
// stalls the pipe while busy and presents {hi,lo} until the pipeline advances.
//
//  state      | meaning
//  -----------+-------------------------------------------------------------
//  ST_IDLE    | no operation in flight; accepts a new MD op from EX
//  ST_DIV_RUN | div_start held high, operands latched, waiting for div_done
//  ST_MUL_RUN | registered product available, copied into hi/lo this cycle
//  ST_HOLD    | res_valid high until pipe_advance; no stall
module muldiv_ctrl
   import muldiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_valid,
   input  logic [2:0]  ex_op,
   input  logic [31:0] ex_opa,
   input  logic [31:0] ex_opb,
   input  logic        flush,
   input  logic        pipe_advance,
   output logic        stall_req,
   output logic        div_start,
   output logic        div_unsigned,
   output logic [31:0] div_opa,
   output logic [31:0] div_opb,
   input  logic [63:0] div_result,
   input  logic        div_done,
   output logic        res_valid,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   md_state_e   state;
   md_state_e   state_nxt;
   logic        div_start_nxt;
   logic        div_unsigned_nxt;
   logic        res_valid_nxt;
   logic [31:0] div_opa_nxt;
   logic [31:0] div_opb_nxt;
   logic [31:0] res_hi_nxt;
   logic [31:0] res_lo_nxt;

   logic        op_mul;
   logic        op_div;
   logic        issue;
   logic        mul_signed;
   logic        mul_load;
   logic [32:0] mul_a;
   logic [32:0] mul_b;
   logic [63:0] product;

   // Undefined opcodes fall through both decodes and therefore never issue.
   assign op_mul     = md_is_mul(ex_op);
   assign op_div     = md_is_div(ex_op);
   assign issue      = ex_valid & (op_mul | op_div) & ~flush & (state == ST_IDLE);
   assign stall_req  = issue | (state == ST_DIV_RUN) | (state == ST_MUL_RUN);

   assign mul_signed = (ex_op == MD_MULT);
   assign mul_a      = {mul_signed & ex_opa[31], ex_opa};
   assign mul_b      = {mul_signed & ex_opb[31], ex_opb};
   assign mul_load   = issue & op_mul;

   muldiv_mul33 u_mul33 (
      .clock   (clock),
      .reset   (reset),
      .load    (mul_load),
      .a       (mul_a),
      .b       (mul_b),
      .product (product)
   );

   always_comb begin
      state_nxt        = state;
      div_start_nxt    = div_start;
      div_unsigned_nxt = div_unsigned;
      div_opa_nxt      = div_opa;
      div_opb_nxt      = div_opb;
      res_valid_nxt    = res_valid;
      res_hi_nxt       = res_hi;
      res_lo_nxt       = res_lo;

      case (state)
         ST_IDLE: begin
            if (issue && op_div) begin
               state_nxt        = ST_DIV_RUN;
               div_start_nxt    = 1'b1;
               div_unsigned_nxt = (ex_op == MD_DIVU);
               div_opa_nxt      = ex_opa;
               div_opb_nxt      = ex_opb;
            end else if (issue) begin
               state_nxt = ST_MUL_RUN;
            end
         end
         ST_DIV_RUN: begin
            if (div_done) begin
               state_nxt     = ST_HOLD;
               div_start_nxt = 1'b0;
               res_valid_nxt = 1'b1;
               res_hi_nxt    = div_result[63:32];
               res_lo_nxt    = div_result[31:0];
            end
         end
         ST_MUL_RUN: begin
            state_nxt     = ST_HOLD;
            res_valid_nxt = 1'b1;
            res_hi_nxt    = product[63:32];
            res_lo_nxt    = product[31:0];
         end
         ST_HOLD: begin
            if (pipe_advance) begin
               state_nxt     = ST_IDLE;
               res_valid_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // A flush kills whatever is in flight, including a result arriving in the same cycle.
      if (flush) begin
         state_nxt     = ST_IDLE;
         div_start_nxt = 1'b0;
         res_valid_nxt = 1'b0;
         res_hi_nxt    = res_hi;
         res_lo_nxt    = res_lo;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= ST_IDLE;
         div_start    <= 1'b0;
         div_unsigned <= 1'b0;
         div_opa      <= '0;
         div_opb      <= '0;
         res_valid    <= 1'b0;
         res_hi       <= '0;
         res_lo       <= '0;
      end else begin
         state        <= state_nxt;
         div_start    <= div_start_nxt;
         div_unsigned <= div_unsigned_nxt;
         div_opa      <= div_opa_nxt;
         div_opb      <= div_opb_nxt;
         res_valid    <= res_valid_nxt;
         res_hi       <= res_hi_nxt;
         res_lo       <= res_lo_nxt;
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a behavioural 36-cycle divider standing in for div_wrapper.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [2:0]  ex_op;
   logic [31:0] ex_opa;
   logic [31:0] ex_opb;
   logic        flush;
   logic        pipe_advance;
   logic        stall_req;
   logic        div_start;
   logic        div_unsigned;
   logic [31:0] div_opa;
   logic [31:0] div_opb;
   logic [63:0] div_result;
   logic        div_done;
   logic        res_valid;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   always #5 clock = ~clock;

   muldiv_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .ex_valid     (ex_valid),
      .ex_op        (ex_op),
      .ex_opa       (ex_opa),
      .ex_opb       (ex_opb),
      .flush        (flush),
      .pipe_advance (pipe_advance),
      .stall_req    (stall_req),
      .div_start    (div_start),
      .div_unsigned (div_unsigned),
      .div_opa      (div_opa),
      .div_opb      (div_opb),
      .div_result   (div_result),
      .div_done     (div_done),
      .res_valid    (res_valid),
      .res_hi       (res_hi),
      .res_lo       (res_lo)
   );

   // Divider model: done in the 36th cycle of start being high; restarts whenever start drops.
   int     dcnt = 0;
   longint la, lb, lq, lr;
   always @(posedge clock) begin
      if (!div_start) dcnt <= 0;
      else if (dcnt < 35) dcnt <= dcnt + 1;
   end
   assign div_done = div_start && (dcnt == 35);
   always_comb begin
      la = 0; lb = 0; lq = 0; lr = 0;
      div_result = '0;
      if (div_opb == 32'h0) begin
         div_result = {div_opa, 32'hFFFF_FFFF};
      end else if (div_unsigned) begin
         div_result = {div_opa % div_opb, div_opa / div_opb};
      end else begin
         la = longint'($signed(div_opa));
         lb = longint'($signed(div_opb));
         lq = la / lb;
         lr = la % lb;
         div_result = {lr[31:0], lq[31:0]};
      end
   end

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each new result and polices the div_start gap.
   logic rv_prev    = 1'b0;
   logic ds_prev    = 1'b0;
   bit   seen_start = 1'b0;
   int   low_run    = 0;
   always @(negedge clock) begin
      if (res_valid && !rv_prev) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got res_valid=1 hi=%h lo=%h expected no result", res_hi, res_lo);
         end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, 64'(res_hi), 64'(e.hi));
            check({e.name, "_lo"}, 64'(res_lo), 64'(e.lo));
            check({e.name, "_latency_cycle"}, 64'(cyc), 64'(e.due));
         end
      end
      rv_prev = res_valid;
      if (div_start && !ds_prev) begin
         if (seen_start) check("div_start_low_gap_ge2", 64'(low_run >= 2), 64'(1));
         seen_start = 1'b1;
      end
      low_run = div_start ? 0 : low_run + 1;
      ds_prev = div_start;
   end

   // Issue one op at the current negedge, follow it to HOLD, hold for 'hold' cycles, then advance.
   task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                        input int lat, input int exp_stall, input int hold, input bit disturb);
      int st = 0;
      int budget = 0;
      bit held_ok = 1'b1;
      bit is_div = (op == MD_DIV) || (op == MD_DIVU);
      ex_valid = 1'b1; ex_op = op; ex_opa = a; ex_opb = b;
      sb.push_back('{hi, lo, cyc + lat, name});
      #1;
      if (stall_req) st++;
      @(negedge clock);
      if (disturb) begin
         ex_opa = 32'h5; ex_opb = 32'h1;
      end else begin
         ex_valid = 1'b0; ex_op = MD_NONE;
      end
      check({name, "_div_start_t1"}, 64'(div_start), 64'(is_div));
      while (!res_valid && budget < 100) begin
         if (stall_req) st++;
         @(negedge clock);
         budget++;
      end
      if (!res_valid) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got no res_valid within 100 cycles expected res_valid", name);
      end
      check({name, "_stall_cycles"}, 64'(st), 64'(exp_stall));
      for (int i = 0; i < hold; i++) begin
         if (!res_valid || div_start || stall_req) held_ok = 1'b0;
         @(negedge clock);
      end
      if (hold > 0) check({name, "_hold_stable"}, 64'(held_ok && res_valid), 64'(1));
      pipe_advance = 1'b1; ex_valid = 1'b0; ex_op = MD_NONE;
      @(negedge clock);
      pipe_advance = 1'b0;
      check({name, "_res_valid_drop"}, 64'(res_valid), 64'(0));
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_div_start"}, 64'(div_start), 64'(0));
      check({name, "_div_unsigned"}, 64'(div_unsigned), 64'(0));
      check({name, "_div_opab"}, {div_opa, div_opb}, 64'(0));
      check({name, "_res_valid"}, 64'(res_valid), 64'(0));
      check({name, "_res_hilo"}, {res_hi, res_lo}, 64'(0));
      check({name, "_stall_req"}, 64'(stall_req), 64'(0));
   endtask

   initial begin
      int budget;
      reset = 1'b0; ex_valid = 1'b0; ex_op = MD_NONE; ex_opa = '0; ex_opb = '0;
      flush = 1'b0; pipe_advance = 1'b0;
      repeat (3) @(negedge clock);
      check_all_zero("reset_state");
      reset = 1'b1;
      @(negedge clock);

      do_op("mult_neg1x2",   MD_MULT,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 2, 0, 1'b0);
      do_op("multu_ffx2",    MD_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 2, 2, 0, 1'b0);
      do_op("mult_minxmin",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 2, 2, 0, 1'b0);
      do_op("div_m7_2",      MD_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 37, 37, 0, 1'b0);
      do_op("divu_100_7",    MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 37, 37, 5, 1'b0);

      // Flush at T+10 of a divide.
      ex_valid = 1'b1; ex_op = MD_DIV; ex_opa = 32'd1000; ex_opb = 32'd3;
      @(negedge clock);
      ex_valid = 1'b0; ex_op = MD_NONE;
      repeat (9) @(negedge clock);
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_div_start", 64'(div_start), 64'(0));
      check("flush_res_valid", 64'(res_valid), 64'(0));
      check("flush_stall_req", 64'(stall_req), 64'(0));
      repeat (40) @(negedge clock);
      do_op("div_9_3", MD_DIV, 32'd9, 32'd3, 32'd0, 32'd3, 37, 37, 0, 1'b0);

      do_op("div_10_3", MD_DIV, 32'd10, 32'd3, 32'd1, 32'd3, 37, 37, 0, 1'b0);
      do_op("div_20_6", MD_DIV, 32'd20, 32'd6, 32'd2, 32'd3, 37, 37, 0, 1'b0);

      // Flush arriving together with div_done must win.
      ex_valid = 1'b1; ex_op = MD_DIVU; ex_opa = 32'd50; ex_opb = 32'd5;
      @(negedge clock);
      ex_valid = 1'b0; ex_op = MD_NONE;
      budget = 0;
      while (!div_done && budget < 100) begin
         @(negedge clock);
         budget++;
      end
      check("flush_vs_done_seen_done", 64'(div_done), 64'(1));
      flush = 1'b1;
      @(negedge clock);
      flush = 1'b0;
      check("flush_vs_done_res_valid", 64'(res_valid), 64'(0));
      check("flush_vs_done_div_start", 64'(div_start), 64'(0));
      repeat (3) @(negedge clock);

      do_op("div_min_neg1", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 37, 37, 0, 1'b0);
      do_op("divu_by_zero", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 37, 37, 0, 1'b0);
      do_op("div_latched",  MD_DIV,  32'd100, 32'd7, 32'd2, 32'd14, 37, 37, 0, 1'b1);

      // Undefined opcode and flush-at-issue must not start anything.
      ex_valid = 1'b1; ex_op = 3'd7; ex_opa = 32'd3; ex_opb = 32'd4;
      #1;
      check("bad_op_stall", 64'(stall_req), 64'(0));
      @(negedge clock);
      ex_op = MD_MULT; flush = 1'b1;
      #1;
      check("flush_issue_stall", 64'(stall_req), 64'(0));
      @(negedge clock);
      ex_valid = 1'b0; ex_op = MD_NONE; flush = 1'b0;
      check("no_issue_div_start", 64'(div_start), 64'(0));
      check("no_issue_stall", 64'(stall_req), 64'(0));
      repeat (4) @(negedge clock);

      // Reset in the middle of a DIVU clears everything on the next cycle.
      ex_valid = 1'b1; ex_op = MD_DIVU; ex_opa = 32'd77; ex_opb = 32'd8;
      @(negedge clock);
      ex_valid = 1'b0; ex_op = MD_NONE;
      repeat (5) @(negedge clock);
      check("pre_reset_div_unsigned", 64'(div_unsigned), 64'(1));
      reset = 1'b0;
      @(negedge clock);
      check_all_zero("mid_div_reset");
      reset = 1'b1;
      repeat (40) @(negedge clock);

      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
